d_flip_flop: RTL and testbench

- Parameterised D-type register with complementary outputs. It samples `d` on each rising clock edge and drives `q` and its bitwise inverse `q_bar`.
- Used as a leaf storage/pipeline element and as a small test vehicle for analysis tooling.
- Single clock domain; no enable, no handshake.

---
 rtl/d_flip_flop_pkg.sv | 17 +
 rtl/d_flip_flop_stage.sv | 29 ++
 rtl/d_flip_flop.sv | 55 +++++
 tb/tb_d_flip_flop.sv | 138 +++++++++++++
 4 files changed

// File: rtl/d_flip_flop_pkg.sv
// Shared constants and helpers for the d_flip_flop register family.
// The latency helper reflects the D_FLIP_FLOP_SYNC_EN build option.
package d_flip_flop_pkg;

  localparam int DFF_MAX_WIDTH = 64;
  localparam logic [DFF_MAX_WIDTH-1:0] DFF_DEFAULT_RESET_VAL = '0;

  // Edges from d to q: one normally, two when the synchroniser stage is built in.
  function automatic int dffLatency();
`ifdef D_FLIP_FLOP_SYNC_EN
    return 2;
`else
    return 1;
`endif
  endfunction

endpackage

// File: rtl/d_flip_flop_stage.sv
// Single WIDTH-bit register with synchronous active-low reset.
// Under D_FLIP_FLOP_SYNC_EN the register is tagged ASYNC_REG/keep for synchroniser use.
module d_flip_flop_stage #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

`ifdef D_FLIP_FLOP_SYNC_EN
  (* ASYNC_REG = "TRUE", keep = "true" *) logic [WIDTH-1:0] r_q;
`else
  logic [WIDTH-1:0] r_q;
`endif

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_q <= RESET_VAL;
    end else begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/d_flip_flop.sv
// Parameterised D register with complementary outputs; q_bar is derived from q, never stored.
// Define D_FLIP_FLOP_SYNC_EN to add a second (synchroniser) stage in front of the output stage.
module d_flip_flop
  import d_flip_flop_pkg::*;
#(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = DFF_DEFAULT_RESET_VAL[WIDTH-1:0]
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_bar
);

  logic [WIDTH-1:0] w_stageIn;
  logic [WIDTH-1:0] w_q;

  if (WIDTH < 1 || WIDTH > DFF_MAX_WIDTH) begin : g_widthCheck
    $error("d_flip_flop: WIDTH %0d outside 1..%0d", WIDTH, DFF_MAX_WIDTH);
  end

`ifdef D_FLIP_FLOP_SYNC_EN
  d_flip_flop_stage #(
    .WIDTH    (WIDTH),
    .RESET_VAL(RESET_VAL)
  ) u_syncStage (
    .i_clk  (clk),
    .i_reset(reset),
    .i_d    (d),
    .o_q    (w_stageIn)
  );
`else
  assign w_stageIn = d;
`endif

  d_flip_flop_stage #(
    .WIDTH    (WIDTH),
    .RESET_VAL(RESET_VAL)
  ) u_outStage (
    .i_clk  (clk),
    .i_reset(reset),
    .i_d    (w_stageIn),
    .o_q    (w_q)
  );

  // Inverting the single stored value keeps q_bar locked to q by construction.
  assign q     = w_q;
  assign q_bar = ~w_q;

`ifndef SYNTHESIS
  a_qBarComplement: assert property (@(posedge clk) q_bar === ~q);
`endif

endmodule

// File: tb/tb_d_flip_flop.sv
// Self-checking bench for d_flip_flop (WIDTH=1 and WIDTH=8/RESET_VAL=A5 instances).
// Expected q is derived from the recorded d/reset history; works with or without D_FLIP_FLOP_SYNC_EN.
module tb_d_flip_flop;
  import d_flip_flop_pkg::*;

  localparam int MAX_EDGES = 1024;

  logic       clk   = 1'b0;
  logic       reset = 1'b0;
  logic       d1    = 1'b0;
  logic [7:0] d8    = 8'h00;
  logic       q1, qBar1;
  logic [7:0] q8, qBar8;

  int         latency;
  int         edgeCount  = 0;
  int         checkCount = 0;
  int         passCount  = 0;
  logic       rstHist[MAX_EDGES];
  logic       dHist1[MAX_EDGES];
  logic [7:0] dHist8[MAX_EDGES];

  d_flip_flop #(.WIDTH(1)) dut1 (
    .clk  (clk),
    .reset(reset),
    .d    (d1),
    .q    (q1),
    .q_bar(qBar1)
  );

  d_flip_flop #(.WIDTH(8), .RESET_VAL(8'hA5)) dut8 (
    .clk  (clk),
    .reset(reset),
    .d    (d8),
    .q    (q8),
    .q_bar(qBar8)
  );

  always #5 clk = ~clk;

  // q after the latest edge: reset value if any edge in the latency window saw reset low,
  // otherwise whatever d was at the oldest edge of that window.
  function automatic logic [7:0] modelQ(input bit wide);
    int last  = edgeCount - 1;
    int first = last - latency + 1;
    for (int k = first; k <= last; k++) begin
      if (k < 0 || !rstHist[k]) return wide ? 8'hA5 : 8'h00;
    end
    return wide ? dHist8[first] : {7'b0, dHist1[first]};
  endfunction

  task automatic compare(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else $error("FAIL %s: observed %h expected %h (edge %0d)", tag, observed, expected, edgeCount);
  endtask

  task automatic checkOutput(input string tag);
    logic [7:0] exp8;
    logic [7:0] exp1;
    exp8 = modelQ(1'b1);
    exp1 = modelQ(1'b0);
    compare({tag, ".q1"},    {7'b0, q1},    exp1);
    compare({tag, ".qbar1"}, {7'b0, qBar1}, {7'b0, ~exp1[0]});
    compare({tag, ".q8"},    q8,            exp8);
    compare({tag, ".qbar8"}, qBar8,         ~exp8);
  endtask

  task automatic applyStimulus(input logic rstVal, input logic dVal1, input logic [7:0] dVal8);
    @(negedge clk);
    reset = rstVal;
    d1    = dVal1;
    d8    = dVal8;
  endtask

  task automatic clockEdge(input string tag);
    @(posedge clk);
    if (edgeCount < MAX_EDGES) begin
      rstHist[edgeCount] = reset;
      dHist1[edgeCount]  = d1;
      dHist8[edgeCount]  = d8;
      edgeCount++;
    end
    #1;
    checkOutput(tag);
  endtask

  initial begin
    latency = dffLatency();

    applyStimulus(1'b0, 1'b1, 8'hFF);
    clockEdge("reset0");
    clockEdge("reset1");

    applyStimulus(1'b1, 1'b1, 8'h3C);
    clockEdge("capture1");
    applyStimulus(1'b1, 1'b0, 8'h3C);
    clockEdge("capture0");
    clockEdge("hold0");
    clockEdge("hold1");

    applyStimulus(1'b1, 1'b1, 8'h81);
    repeat (latency) clockEdge("preload");
    applyStimulus(1'b0, 1'b1, 8'h81);
    #1;
    checkOutput("resetMidCycle");
    clockEdge("resetEdge");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'($urandom), 8'($urandom));
      clockEdge("resetHeld");
    end

    applyStimulus(1'b1, 1'b1, 8'h66);
    clockEdge("release");
    clockEdge("releaseNext");

    applyStimulus(1'b1, 1'b0, 8'h00);
    repeat (latency) clockEdge("settle0");
    @(negedge clk);
    d1 = 1'b1;
    d8 = 8'hFF;
    #1;
    d1 = 1'b0;
    d8 = 8'h00;
    #1;
    checkOutput("glitchMid");
    clockEdge("glitchEdge");

    for (int i = 0; i < 200; i++) begin
      applyStimulus(($urandom_range(0, 7) != 0), 1'($urandom), 8'($urandom));
      clockEdge("random");
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
